// File: rtl/cnn_pkg.sv
// Shared parameters, types and the pixel-by-weight multiply for the CNN convolution front end.
package cnn_pkg;

  localparam int I_F_BW = 8;
  localparam int O_F_BW = 23;
  localparam int W_BW   = 7;
  localparam int KX     = 5;
  localparam int KY     = 5;
  localparam int CI     = 1;
  localparam int CO     = 3;
  localparam int IX     = 28;
  localparam int IY     = 28;

  localparam int OUT_W  = IX - KX + 1;
  localparam int OUT_H  = IY - KY + 1;
  localparam int NTAP   = KX * KY;
  localparam int P_BW   = I_F_BW + W_BW + 1;
  localparam int XW     = $clog2(IX);
  localparam int YW     = $clog2(IY);
  localparam int OCNT_W = $clog2(OUT_W * OUT_H);

  typedef logic signed [P_BW-1:0]   prod_t;
  typedef logic signed [O_F_BW-1:0] acc_t;

  // Pixel is unsigned, weight is two's complement; both widened before the multiply.
  function automatic prod_t mul_px_w(input logic [I_F_BW-1:0] px, input logic [W_BW-1:0] w);
    prod_t a;
    prod_t b;
    a = prod_t'(signed'({1'b0, px}));
    b = prod_t'(signed'(w));
    return a * b;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// Raster counters, KY-1 line buffers and the KX x KY sliding window feeding the MAC stage.
module cnn_line_buffer
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  input  logic [I_F_BW-1:0]       i_pixel,
  output logic [KX*KY*I_F_BW-1:0] o_window,
  output logic [KY*I_F_BW-1:0]    o_line_buf,
  output logic                    o_win_valid
);

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [I_F_BW-1:0] lb_mem_q [KY-1][IX];
  logic [I_F_BW-1:0] col      [KY];
  logic [I_F_BW-1:0] win_q    [KY][KX];
  logic [I_F_BW-1:0] win_d    [KY][KX];
  logic [I_F_BW-1:0] lbo_q    [KY];
  logic [I_F_BW-1:0] lbo_d    [KY];
  logic              win_valid_q, win_valid_d;

  // Column at x: oldest row in buffer 0, newest pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KY-1; r++) col[r] = lb_mem_q[r][x_q];
    col[KY-1] = i_pixel;
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    win_d       = win_q;
    lbo_d       = lbo_q;
    win_valid_d = 1'b0;
    if (i_valid) begin
      if (x_q == XW'(IX-1)) begin
        x_d = '0;
        y_d = (y_q == YW'(IY-1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      for (int r = 0; r < KY; r++) begin
        for (int c = 0; c < KX-1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][KX-1] = col[r];
      end
      lbo_d       = col;
      win_valid_d = (x_q >= XW'(KX-1)) && (y_q >= YW'(KY-1));
    end
  end

  // Line-buffer RAM has no reset; every entry is rewritten before it reaches a valid window.
  always_ff @(posedge clk) begin
    if (i_valid && !reset_n) begin
      for (int r = 0; r < KY-1; r++) lb_mem_q[r][x_q] <= col[r+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < KY; r++) begin
        lbo_q[r] <= '0;
        for (int c = 0; c < KX; c++) win_q[r][c] <= '0;
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      win_valid_q <= win_valid_d;
      lbo_q       <= lbo_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    for (int r = 0; r < KY; r++) begin
      o_line_buf[r*I_F_BW +: I_F_BW] = lbo_q[r];
      for (int c = 0; c < KX; c++) o_window[(r*KX+c)*I_F_BW +: I_F_BW] = win_q[r][c];
    end
  end

  assign o_win_valid = win_valid_q;

endmodule

// File: rtl/cnn_conv_top.sv
// 5x5 streaming convolution: line buffer/window, registered products, bias-added sum and frame-done pulse.
module cnn_conv_top
  import cnn_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_valid,
  input  logic [I_F_BW-1:0]            i_pixel,
  input  logic [CO*CI*KX*KY*W_BW-1:0]  i_cnn_weight,
  input  logic [CO*W_BW-1:0]           i_cnn_bias,
  output logic                         o_valid,
  output logic [CO*O_F_BW-1:0]         o_ot_fmap,
  output logic                         o_done,
  output logic [KX*KY*I_F_BW-1:0]      o_window,
  output logic [KX*I_F_BW-1:0]         o_line_buf
);

  localparam logic [OCNT_W-1:0] LAST_OUT = OCNT_W'(OUT_W*OUT_H - 1);

  logic                    win_valid;
  prod_t                   prod_q [CO][NTAP];
  prod_t                   prod_d [CO][NTAP];
  logic                    prod_valid_q, prod_valid_d;
  logic signed [W_BW-1:0]  bias_s [CO];
  acc_t                    acc    [CO];
  acc_t                    fmap_q [CO];
  acc_t                    fmap_d [CO];
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [OCNT_W-1:0]       ocnt_q, ocnt_d;

  cnn_line_buffer u_line_buffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (i_valid),
    .i_pixel     (i_pixel),
    .o_window    (o_window),
    .o_line_buf  (o_line_buf),
    .o_win_valid (win_valid)
  );

  always_comb begin
    prod_d       = prod_q;
    prod_valid_d = win_valid;
    if (win_valid) begin
      for (int co = 0; co < CO; co++) begin
        for (int k = 0; k < NTAP; k++) begin
          prod_d[co][k] = mul_px_w(o_window[k*I_F_BW +: I_F_BW],
                                   i_cnn_weight[(k*CO+co)*W_BW +: W_BW]);
        end
      end
    end
  end

  // Worst case |sum| stays within 20 bits, so O_F_BW accumulation never wraps.
  always_comb begin
    for (int co = 0; co < CO; co++) begin
      bias_s[co] = signed'(i_cnn_bias[co*W_BW +: W_BW]);
      acc[co]    = acc_t'(bias_s[co]);
      for (int k = 0; k < NTAP; k++) acc[co] = acc[co] + acc_t'(prod_q[co][k]);
    end
  end

  always_comb begin
    fmap_d  = fmap_q;
    valid_d = prod_valid_q;
    done_d  = 1'b0;
    ocnt_d  = ocnt_q;
    if (prod_valid_q) begin
      fmap_d = acc;
      done_d = (ocnt_q == LAST_OUT);
      ocnt_d = (ocnt_q == LAST_OUT) ? '0 : ocnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      prod_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      ocnt_q       <= '0;
      for (int co = 0; co < CO; co++) begin
        fmap_q[co] <= '0;
        for (int k = 0; k < NTAP; k++) prod_q[co][k] <= '0;
      end
    end else begin
      prod_valid_q <= prod_valid_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      ocnt_q       <= ocnt_d;
      fmap_q       <= fmap_d;
      prod_q       <= prod_d;
    end
  end

  always_comb begin
    for (int co = 0; co < CO; co++) o_ot_fmap[co*O_F_BW +: O_F_BW] = fmap_q[co];
  end

  assign o_valid = valid_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_cnn_conv_top.sv
// Directed and randomized frames checked against an image-level convolution model.
module tb_cnn_conv_top;
  import cnn_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        i_valid;
  logic [I_F_BW-1:0]           i_pixel;
  logic [CO*CI*KX*KY*W_BW-1:0] i_cnn_weight;
  logic [CO*W_BW-1:0]          i_cnn_bias;
  logic                        o_valid;
  logic [CO*O_F_BW-1:0]        o_ot_fmap;
  logic                        o_done;
  logic [KX*KY*I_F_BW-1:0]     o_window;
  logic [KX*I_F_BW-1:0]        o_line_buf;

  int checks = 0;
  int errors = 0;
  int got_q[$];
  int exp_q[$];
  int done_cnt = 0;
  int done_idx = -1;
  int cyc = 0;
  int first_valid_cyc = -1;
  int win_cyc = -1;
  int img[IX*IY];
  int wt[CO][KX*KY];
  int bs[CO];

  cnn_conv_top dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_pixel      (i_pixel),
    .i_cnn_weight (i_cnn_weight),
    .i_cnn_bias   (i_cnn_bias),
    .o_valid      (o_valid),
    .o_ot_fmap    (o_ot_fmap),
    .o_done       (o_done),
    .o_window     (o_window),
    .o_line_buf   (o_line_buf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_valid) begin
      if (got_q.size() == 0) first_valid_cyc = cyc;
      for (int co = 0; co < CO; co++) got_q.push_back(int'($signed(o_ot_fmap[co*O_F_BW +: O_F_BW])));
    end
    if (o_done) begin
      done_cnt++;
      done_idx = got_q.size() / CO;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_params();
    for (int co = 0; co < CO; co++) begin
      i_cnn_bias[co*W_BW +: W_BW] = bs[co][W_BW-1:0];
      for (int k = 0; k < KX*KY; k++) i_cnn_weight[(k*CO+co)*W_BW +: W_BW] = wt[co][k][W_BW-1:0];
    end
  endtask

  // Valid-padding convolution over the whole image, emitted in raster order of output positions.
  task automatic build_expect();
    exp_q.delete();
    for (int oy = 0; oy < OUT_H; oy++)
      for (int ox = 0; ox < OUT_W; ox++)
        for (int co = 0; co < CO; co++) begin
          int s;
          s = bs[co];
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
              s += img[(oy+ky)*IX + ox + kx] * wt[co][ky*KX+kx];
          exp_q.push_back(s);
        end
  endtask

  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0;
    done_idx = -1;
    first_valid_cyc = -1;
  endtask

  task automatic drive_pixel(input int p);
    @(negedge clk);
    i_valid = 1'b1;
    i_pixel = p[I_F_BW-1:0];
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  function automatic int rand_w();
    int c;
    c = int'($urandom_range(0, 127));
    return (c >= 64) ? c - 128 : c;
  endfunction

  task automatic set_weights(input int w_all, input int b_all);
    for (int co = 0; co < CO; co++) begin
      bs[co] = b_all;
      for (int k = 0; k < KX*KY; k++) wt[co][k] = w_all;
    end
  endtask

  // mode 0: continuous, 1: one idle cycle after every pixel, 2: random idle cycles
  task automatic run_frame(input int mode, input bit check_win);
    for (int i = 0; i < IX*IY; i++) begin
      drive_pixel(img[i]);
      if (check_win && i == (KY-1)*IX + KX-1) begin
        win_cyc = cyc;
        for (int r = 0; r < KY; r++) begin
          for (int c = 0; c < KX; c++)
            check($sformatf("window_r%0d_c%0d", r, c), longint'(o_window[(r*KX+c)*I_F_BW +: I_F_BW]), img[r*IX+c]);
          check($sformatf("line_buf_%0d", r), longint'(o_line_buf[r*I_F_BW +: I_F_BW]), img[r*IX + KX-1]);
        end
      end
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_frame(input string tag);
    int bad;
    int n;
    bad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) bad++;
    check({tag, "_mismatches"}, bad, 0);
    if (n > 0) begin
      check({tag, "_first"}, got_q[0], exp_q[0]);
      check({tag, "_last"}, got_q[n-1], exp_q[n-1]);
    end
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_at"}, done_idx, OUT_W*OUT_H);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_o_valid"}, o_valid, 0);
    check({tag, "_o_done"}, o_done, 0);
    check({tag, "_fmap_ones"}, $countones(o_ot_fmap), 0);
    check({tag, "_window_ones"}, $countones(o_window), 0);
    check({tag, "_line_buf_ones"}, $countones(o_line_buf), 0);
  endtask

  initial begin
    reset_n      = 1'b1;
    i_valid      = 1'b0;
    i_pixel      = '0;
    i_cnn_weight = '0;
    i_cnn_bias   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b0;

    // Ramp image, unit weights, zero bias
    for (int i = 0; i < IX*IY; i++) img[i] = (i + 1) % 256;
    set_weights(1, 0);
    apply_params();
    build_expect();
    clear_obs();
    run_frame(0, 1'b1);
    compare_frame("ramp");
    check("ramp_first_ch0", got_q[0], 1475);
    check("ramp_first_ch2", got_q[2], 1475);
    check("ramp_second_ch0", got_q[3], 1500);
    // o_valid is visible during the third cycle after the accepting edge, i.e. after edge n+2
    check("ramp_latency", first_valid_cyc - win_cyc, 2);

    // Negative weights on channel 1, bias on channel 2
    for (int k = 0; k < KX*KY; k++) wt[1][k] = -1;
    bs[2] = 5;
    apply_params();
    build_expect();
    clear_obs();
    run_frame(0, 1'b0);
    compare_frame("signbias");
    check("signbias_ch0", got_q[0], 1475);
    check("signbias_ch1", got_q[1], -1475);
    check("signbias_ch2", got_q[2], 1480);

    // Alternating i_valid must not change values or count
    set_weights(1, 0);
    apply_params();
    build_expect();
    clear_obs();
    run_frame(1, 1'b0);
    compare_frame("toggle");

    // Saturated corner: all-255 pixels against extreme weights and biases
    for (int i = 0; i < IX*IY; i++) img[i] = 255;
    for (int k = 0; k < KX*KY; k++) begin
      wt[0][k] = 63;
      wt[1][k] = -64;
      wt[2][k] = (k % 2 == 0) ? -64 : 63;
    end
    bs[0] = 63;
    bs[1] = -64;
    bs[2] = -1;
    apply_params();
    build_expect();
    clear_obs();
    run_frame(0, 1'b0);
    compare_frame("extreme");
    check("extreme_ch1", got_q[1], 25*255*(-64) - 64);

    // Random image and coefficients with random gaps
    for (int i = 0; i < IX*IY; i++) img[i] = int'($urandom_range(0, 255));
    for (int co = 0; co < CO; co++) begin
      bs[co] = rand_w();
      for (int k = 0; k < KX*KY; k++) wt[co][k] = rand_w();
    end
    apply_params();
    build_expect();
    clear_obs();
    run_frame(2, 1'b0);
    compare_frame("random");

    // Abort a frame with a one-cycle reset that coincides with i_valid, then a clean frame
    for (int i = 0; i < 300; i++) drive_pixel(int'($urandom_range(0, 255)));
    @(negedge clk);
    reset_n = 1'b1;
    i_valid = 1'b1;
    i_pixel = 8'hAA;
    @(posedge clk);
    #1;
    check_zero_outputs("midreset");
    reset_n = 1'b0;
    i_valid = 1'b0;
    clear_obs();
    for (int i = 0; i < IX*IY; i++) img[i] = int'($urandom_range(0, 255));
    build_expect();
    run_frame(0, 1'b0);
    compare_frame("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
